// File: rtl/sr_sched_pkg.sv
// Shared types for the SR bank scheduler: command encoding, its decoder and
// the default bank geometry.
package sr_sched_pkg;
  localparam int NREQ_DEF  = 4;
  localparam int NBITS_DEF = 8;

  typedef enum logic [1:0] {
    CMD_HOLD   = 2'b00,
    CMD_RESET  = 2'b01,
    CMD_SET    = 2'b10,
    CMD_FORBID = 2'b11
  } sr_cmd_e;

  function automatic sr_cmd_e decode_sr(input logic s, input logic r);
    return sr_cmd_e'({s, r});
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr,
// ptr moves past the winner whenever a grant is issued.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] gnt_id_o,
  output logic         gnt_any_o
);
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] cand;
  logic [N-1:0] gnt;
  logic [W-1:0] gnt_id;
  logic         found;

  // Scan downward so the candidate closest to ptr is written last and wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = W'((32'(ptr_q) + k) % N);
      if (req_i[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        gnt_id    = cand;
        found     = 1'b1;
      end
    end
  end

  // Grants are suppressed during reset so nothing is accepted.
  assign gnt_any_o = found & ~rst;
  assign gnt_o     = rst ? '0 : gnt;
  assign gnt_id_o  = gnt_id;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any_o)
      ptr_d = (32'(gnt_id) == N - 1) ? '0 : gnt_id + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/sr_bank_scheduler.sv
// Arbitrates set/reset/hold commands from several requesters onto a single
// bank of SR bits; illegal commands are dropped and flagged.
module sr_bank_scheduler
  import sr_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int NBITS = NBITS_DEF,
  parameter int IDW   = $clog2(NBITS),
  parameter int RQW   = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ-1:0]     req_s,
  input  logic [NREQ-1:0]     req_r,
  input  logic [NREQ*IDW-1:0] req_idx,
  output logic [NREQ-1:0]     req_ready,
  output logic [NBITS-1:0]    q,
  output logic [NBITS-1:0]    q_bar,
  output logic                err_pulse,
  output logic [RQW-1:0]      err_src,
  output logic                busy
);
  logic [RQW-1:0]   gnt_id;
  logic             gnt_any;
  logic [IDW-1:0]   sel_idx;
  sr_cmd_e          sel_cmd;
  logic             bad;

  logic [NBITS-1:0] q_q, q_d;
  logic             err_q, err_d;
  logic [RQW-1:0]   src_q, src_d;

  rr_arbiter #(.N(NREQ), .W(RQW)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_valid),
    .gnt_o    (req_ready),
    .gnt_id_o (gnt_id),
    .gnt_any_o(gnt_any)
  );

  assign sel_idx = req_idx[gnt_id*IDW +: IDW];
  assign sel_cmd = decode_sr(req_s[gnt_id], req_r[gnt_id]);
  assign bad     = (sel_cmd == CMD_FORBID) || (32'(sel_idx) >= NBITS);

  always_comb begin
    q_d = q_q;
    if (gnt_any && !bad) begin
      for (int b = 0; b < NBITS; b++) begin
        if (sel_idx == IDW'(b)) begin
          if (sel_cmd == CMD_SET)   q_d[b] = 1'b1;
          if (sel_cmd == CMD_RESET) q_d[b] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    err_d = gnt_any & bad;
    src_d = err_d ? gnt_id : src_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= '0;
      err_q <= 1'b0;
      src_q <= '0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
      src_q <= src_d;
    end
  end

  assign q         = q_q;
  assign q_bar     = ~q_q;
  assign err_pulse = err_q;
  assign err_src   = src_q;
  assign busy      = |req_valid;
endmodule

// File: tb/tb_sr_bank_scheduler.sv
// Drives an 8-bit and a 6-bit bank with identical commands and compares both
// against a simple bank/pointer model.
module tb_sr_bank_scheduler;
  localparam int NREQ = 4;
  localparam int IDW  = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid, req_s, req_r;
  logic [NREQ*IDW-1:0] req_idx;
  logic [NREQ-1:0]     rdy_a, rdy_b;
  logic [7:0]          q_a, qb_a;
  logic [5:0]          q_b, qb_b;
  logic                err_a, err_b, busy_a, busy_b;
  logic [1:0]          src_a, src_b;

  int errors = 0;
  int checks = 0;

  int         ptr;
  logic [7:0] m_a;
  logic [5:0] m_b;
  logic       me_a, me_b;
  int         ms_a, ms_b;
  int         last_g;

  always #5 clk = ~clk;

  sr_bank_scheduler #(.NREQ(4), .NBITS(8)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_s(req_s), .req_r(req_r),
    .req_idx(req_idx), .req_ready(rdy_a), .q(q_a), .q_bar(qb_a),
    .err_pulse(err_a), .err_src(src_a), .busy(busy_a)
  );

  sr_bank_scheduler #(.NREQ(4), .NBITS(6)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_s(req_s), .req_r(req_r),
    .req_idx(req_idx), .req_ready(rdy_b), .q(q_b), .q_bar(qb_b),
    .err_pulse(err_b), .err_src(src_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic s, input logic r, input int ix);
    req_valid[i]            = v;
    req_s[i]                = s;
    req_r[i]                = r;
    req_idx[i*IDW +: IDW]   = IDW'(ix);
  endtask

  task automatic clear_reqs();
    req_valid = '0; req_s = '0; req_r = '0; req_idx = '0;
  endtask

  function automatic int exp_grant();
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    ptr = 0; m_a = '0; m_b = '0; me_a = 0; me_b = 0; ms_a = 0; ms_b = 0; last_g = -1;
  endtask

  // One clock: check grant before the edge, update the model, check state after.
  task automatic cycle();
    int g;
    int cmd;
    int ix;
    logic [31:0] eg;
    logic [7:0] nb_a;
    logic [5:0] nb_b;
    #1;
    g  = exp_grant();
    eg = (g < 0) ? 32'd0 : (32'd1 << g);
    check("ready_a", rdy_a, eg);
    check("ready_b", rdy_b, eg);
    check("busy", busy_a, |req_valid);
    @(posedge clk);
    last_g = g;
    me_a = 0; me_b = 0;
    if (g >= 0) begin
      cmd = {req_s[g], req_r[g]};
      ix  = int'(req_idx[g*IDW +: IDW]);
      ptr = (g + 1) % NREQ;
      if (cmd == 3 || ix >= 8) begin me_a = 1; ms_a = g; end
      else if (cmd == 2) m_a[ix] = 1'b1;
      else if (cmd == 1) m_a[ix] = 1'b0;
      if (cmd == 3 || ix >= 6) begin me_b = 1; ms_b = g; end
      else if (cmd == 2) m_b[ix] = 1'b1;
      else if (cmd == 1) m_b[ix] = 1'b0;
    end
    @(negedge clk);
    nb_a = ~m_a;
    nb_b = ~m_b;
    check("q_a", q_a, m_a);
    check("qbar_a", qb_a, nb_a);
    check("err_a", err_a, me_a);
    check("src_a", src_a, ms_a);
    check("q_b", q_b, m_b);
    check("qbar_b", qb_b, nb_b);
    check("err_b", err_b, me_b);
    check("src_b", src_b, ms_b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '1;
    #1;
    check("rst_ready_a", rdy_a, 0);
    check("rst_ready_b", rdy_b, 0);
    check("rst_q_a", q_a, 8'h00);
    check("rst_qbar_a", qb_a, 8'hFF);
    check("rst_err_a", err_a, 0);
    check("rst_src_a", src_a, 0);
    check("rst_q_b", q_b, 6'h00);
    check("rst_qbar_b", qb_b, 6'h3F);
    @(negedge clk);
    @(negedge clk);
    check("rst_hold_ready", rdy_a, 0);
    rst = 1'b0;
    model_reset();
    clear_reqs();
  endtask

  initial begin
    rst = 1'b1;
    clear_reqs();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single set then reset of bit 3
    set_req(0, 1, 1, 0, 3); cycle();
    check("set_idx3", q_a, 8'h08);
    set_req(0, 1, 0, 1, 3); cycle();
    check("reset_idx3", q_a, 8'h00);
    clear_reqs(); cycle();

    // Fairness: everyone sets its own bit, continuously valid
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 1, 0, i);
    for (int c = 0; c < 4; c++) cycle();
    check("fair_q", q_a, 8'h0F);
    for (int c = 0; c < 4; c++) cycle();

    // Reset mid-stream with all requesters valid, then first grant goes to 0
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 0, 0);
    #1 check("post_rst_grant0", rdy_a, 4'b0001);
    cycle();
    clear_reqs();
    do_reset();

    // Forbidden from requester 2 with q=0x20 and ptr at 2
    set_req(0, 1, 1, 0, 5); cycle();
    clear_reqs(); set_req(1, 1, 0, 0, 0); cycle();
    clear_reqs(); set_req(2, 1, 1, 1, 5); cycle();
    check("forbid_q", q_a, 8'h20);
    check("forbid_err", err_a, 1);
    check("forbid_src", src_a, 2);
    check("forbid_ptr", ptr, 3);
    clear_reqs(); cycle();
    check("forbid_err_drop", err_a, 0);

    // Out-of-range on the 6-bit bank
    set_req(1, 1, 1, 0, 7); cycle();
    check("oor_q_b", q_b, 6'h20);
    check("oor_err_b", err_b, 1);
    check("oor_src_b", src_b, 1);
    clear_reqs(); cycle();

    // Same-bit contention from ptr=0
    do_reset();
    set_req(0, 1, 1, 0, 0);
    set_req(1, 1, 0, 1, 0);
    cycle();
    check("contend_first", q_a[0], 1);
    set_req(0, 0, 0, 0, 0);
    cycle();
    check("contend_second", q_a[0], 0);
    clear_reqs(); cycle();

    // Back-to-back forbidden commands
    set_req(0, 1, 1, 1, 1);
    set_req(3, 1, 1, 1, 2);
    cycle();
    set_req(0, 0, 0, 0, 0);
    cycle();
    check("b2b_err", err_a, 1);
    check("b2b_src", src_a, 3);
    clear_reqs(); cycle();

    // Random traffic; a requester may only change its command once granted
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || i == last_g)
          set_req(i, $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 7)));
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sr_bank_scheduler.md
# sr_bank_scheduler

Shares one bank of SR flip-flop bits between several requesters. Each requester issues set/reset/hold commands addressed to one bit. A round-robin scheduler grants at most one command per clock and applies it to the bank. Forbidden S=R=1 commands and out-of-range bit indices are rejected without touching state and reported on an error pulse. The block sits in front of the SR storage and is the only writer to it.

## Interface
- NREQ, 4, number of requesters (2..8)
- NBITS, 8, number of SR bits in the bank (2..32)
- IDW, $clog2(NBITS), width of a bit index
- RQW, $clog2(NREQ), width of a requester id
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NREQ  requester i has a command pending
- req_s  input  NREQ  S input of requester i's command
- req_r  input  NREQ  R input of requester i's command
- req_idx  input  NREQ*IDW  target bit of requester i, slice [i*IDW +: IDW]
- req_ready  output  NREQ  one-hot grant, combinational; command accepted when valid&ready at rising edge
- q  output  NBITS  registered bank state
- q_bar  output  NBITS  always ~q
- err_pulse  output  1  registered, high one cycle after a rejected command is accepted
- err_src  output  RQW  requester id of the last rejected command, held until the next error
- busy  output  1  combinational OR of req_valid

## Operation
- Command encoding {S,R}: 00 HOLD (no change), 01 RESET (bit←0), 10 SET (bit←1), 11 FORBIDDEN.
- Arbitration: round-robin pointer ptr (RQW bits). Grant goes to the first valid requester at or after ptr, modulo NREQ. At most one req_ready bit is high. req_ready is 0 for requesters with valid=0.
- On an accepted grant to requester g: ptr←(g+1) mod NREQ. With no valid requesters, ptr holds.
- Apply: SET/RESET update q[idx] at the accepting edge. HOLD consumes the grant and changes nothing.
- Reject: FORBIDDEN, or idx ≥ NBITS. q is unchanged, err_pulse=1 the next cycle, and err_src←g. The grant is still consumed and ptr advances.
- Requesters hold valid, s, r and idx stable until ready; inputs may change freely after acceptance.
- Only one bit changes per cycle, so there are no write conflicts. Two requesters targeting the same bit are serialized in round-robin order: the later grant wins.

## Timing
- Reset (async assert, deassert synchronized by the user): q=0, q_bar=all 1, ptr=0, err_pulse=0, err_src=0. req_ready is 0 while rst=1.
- Latency: command accepted at edge N. q visible after edge N; err_pulse is high during cycle N+1 only.
- Throughput: 1 command per cycle. With all NREQ valid, each requester is granted exactly once every NREQ cycles.
- Reset mid-stream: pending requests are not remembered. After release, arbitration restarts from ptr=0.
- Back-to-back errors: err_pulse stays high for consecutive cycles, and err_src updates every cycle.
- Pointer wrap: a grant to requester NREQ-1 sets ptr=0.

## Structure
- Package sr_sched_pkg holds:
  - the command enum (HOLD, RESET, SET, FORBIDDEN) as 2-bit {S,R}
  - a function decoding {S,R} to the enum
  - the default NREQ/NBITS constants
- Sub-module rr_arbiter (parameter N) holds the ptr register and produces the one-hot grant plus the encoded id. All other logic (bank register, decode, error) stays in the top.

## Test plan
- Reset: assert rst mid-run with req_valid=4'b1111 → q=8'h00, q_bar=8'hFF, req_ready=0, err_pulse=0; after release, the first grant goes to requester 0.
- Single set/reset: req0 SET idx=3, then RESET idx=3 → q=8'h08 after the first edge, 8'h00 after the second; q_bar always ~q.
- Fairness: all four requesters valid continuously with SET idx=i → grants in order 0,1,2,3,0,...; q=8'h0F after 4 cycles.
- Forbidden: req2 {S,R}=11 idx=5 with q=8'h20 → q stays 8'h20, err_pulse=1 for exactly one cycle, err_src=2, ptr advances to 3.
- Out-of-range with NBITS=6, IDW=3: req1 SET idx=7 → no q change, err_pulse=1, err_src=1.
- Same-bit contention: req0 SET idx=0 and req1 RESET idx=0 both valid from ptr=0 → q[0]=1 after the first edge, 0 after the second.
